// File: rtl/foxtrot_pkg.sv
// foxtrot_pkg: types and helpers shared by the flush arbiter and its picker.
//   fa_state_e  : arbiter FSM states (IDLE, ISSUE, WAIT)
//   br_req_t    : one branch unit's mispredict report {valid, inst_id, target_pc}
//   id_mask     : all-ones mask for an id of a given width
//   age_of      : distance of an id from the ROB tail, modulo the ROB depth
// ROB ids are carried in a fixed ID_MAX-bit container so a single struct and
// function serve any ROB width up to ID_MAX bits; the real width is passed
// as 'bits' and applied through id_mask.
package foxtrot_pkg;

  localparam int ID_MAX = 16;

  typedef logic [ID_MAX-1:0] id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fa_state_e;

  typedef struct packed {
    logic        valid;
    id_t         inst_id;
    logic [63:0] target_pc;
  } br_req_t;

  function automatic id_t id_mask(input int unsigned bits);
    return (id_t'(1) << bits) - id_t'(1);
  endfunction

  // Smaller age means closer to the tail, i.e. older.
  function automatic id_t age_of(input id_t id, input id_t tail, input int unsigned bits);
    return (id - tail) & id_mask(bits);
  endfunction

endpackage

// File: rtl/flush_arbiter_oldest_select.sv
// oldest_select: combinational BR_COUNT-way picker of the oldest flush target.
//   i_req    : per-lane mispredict reports (inst_id is the branch id)
//   i_tail   : current ROB tail (oldest entry)
//   o_valid  : at least one lane valid
//   o_idx    : winning lane
//   o_target : winning flush target (branch id + 1, wrapped)
//   o_age    : age of o_target relative to i_tail
//   o_pc     : winning lane's redirect target
// Equal ages keep the lowest lane index; this also merges lanes that report
// the same target in one cycle.
module oldest_select
  import foxtrot_pkg::*;
#(
  parameter int BR_COUNT = 2,
  parameter int ID_BITS  = 6,
  parameter int IDX_W    = (BR_COUNT > 1) ? $clog2(BR_COUNT) : 1
) (
  input  br_req_t [BR_COUNT-1:0] i_req,
  input  id_t                    i_tail,
  output logic                   o_valid,
  output logic [IDX_W-1:0]       o_idx,
  output id_t                    o_target,
  output id_t                    o_age,
  output logic [63:0]            o_pc
);

  id_t w_tgt [BR_COUNT];
  id_t w_age [BR_COUNT];

  for (genvar g = 0; g < BR_COUNT; g++) begin : g_lane
    assign w_tgt[g] = (i_req[g].inst_id + id_t'(1)) & id_mask(ID_BITS);
    assign w_age[g] = age_of(w_tgt[g], i_tail, ID_BITS);
  end

  always_comb begin
    o_valid  = 1'b0;
    o_idx    = '0;
    o_target = '0;
    o_age    = '0;
    o_pc     = '0;
    for (int i = 0; i < BR_COUNT; i++) begin
      // strict '<' keeps the earlier lane on an age tie
      if (i_req[i].valid && (!o_valid || (w_age[i] < o_age))) begin
        o_valid  = 1'b1;
        o_idx    = IDX_W'(i);
        o_target = w_tgt[i];
        o_age    = w_age[i];
        o_pc     = i_req[i].target_pc;
      end
    end
  end

endmodule

// File: rtl/flush_arbiter.sv
// flush_arbiter: sole driver of the ROB flush port.
//   br_valid/br_inst_id/br_target_pc : per-branch-unit mispredict reports
//   rob_tail / rob_head               : ROB oldest entry / next-allocate slot
//   rob_stall_rename                  : ROB still busy flushing
//   start_flush / start_flush_to      : one-cycle flush request, first id to squash
//   redirect_valid / redirect_pc      : one-cycle fetch redirect
//   frontend_stall                    : hold fetch/decode while a flush is live
//   busy                              : FSM not idle
//   flush_count                       : saturating count of flushes sent to the ROB
// Every output is a register loaded from the next-state decode, so a report
// seen at one edge shows up on the outputs right after that edge.
// INST_ID_BITS must not exceed foxtrot_pkg::ID_MAX.
module flush_arbiter
  import foxtrot_pkg::*;
#(
  parameter int INST_ID_BITS = 6,
  parameter int BR_COUNT     = 2,
  parameter int CNT_BITS     = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [BR_COUNT-1:0]                     br_valid,
  input  logic [BR_COUNT-1:0][INST_ID_BITS-1:0]   br_inst_id,
  input  logic [BR_COUNT-1:0][63:0]               br_target_pc,
  input  logic [INST_ID_BITS-1:0]                 rob_tail,
  input  logic [INST_ID_BITS-1:0]                 rob_head,
  input  logic                                    rob_stall_rename,
  output logic                                    start_flush,
  output logic [INST_ID_BITS-1:0]                 start_flush_to,
  output logic                                    redirect_valid,
  output logic [63:0]                             redirect_pc,
  output logic                                    frontend_stall,
  output logic                                    busy,
  output logic [CNT_BITS-1:0]                     flush_count
);

  localparam int IDX_W = (BR_COUNT > 1) ? $clog2(BR_COUNT) : 1;

  fa_state_e               r_state;
  fa_state_e               w_next;
  logic [INST_ID_BITS-1:0] r_pend_target;
  logic [63:0]             r_pend_pc;
  logic                    r_start_flush;
  logic                    r_redirect_valid;
  logic                    r_frontend_stall;
  logic                    r_busy;
  logic [CNT_BITS-1:0]     r_flush_count;

  br_req_t [BR_COUNT-1:0]  w_req;
  logic                    w_sel_valid;
  logic [IDX_W-1:0]        w_sel_idx;
  id_t                     w_sel_target;
  id_t                     w_sel_age;
  logic [63:0]             w_sel_pc;
  id_t                     w_pend_age;
  logic                    w_accept;
  logic                    w_redir_only;
  logic                    w_unused_idx;

  for (genvar g = 0; g < BR_COUNT; g++) begin : g_req
    assign w_req[g] = '{valid: br_valid[g], inst_id: id_t'(br_inst_id[g]),
                        target_pc: br_target_pc[g]};
  end

  oldest_select #(
    .BR_COUNT (BR_COUNT),
    .ID_BITS  (INST_ID_BITS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .i_req    (w_req),
    .i_tail   (id_t'(rob_tail)),
    .o_valid  (w_sel_valid),
    .o_idx    (w_sel_idx),
    .o_target (w_sel_target),
    .o_age    (w_sel_age),
    .o_pc     (w_sel_pc)
  );

  // winning lane index is only of debug interest here
  assign w_unused_idx = ^w_sel_idx;

  // re-evaluated against the live tail every cycle
  assign w_pend_age = age_of(id_t'(r_pend_target), id_t'(rob_tail), INST_ID_BITS);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_redir_only = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_sel_valid) begin
          w_accept = 1'b1;
          // target == head: nothing younger to squash, only refetch
          if (w_sel_target == id_t'(rob_head)) w_redir_only = 1'b1;
          else                                 w_next       = ISSUE;
        end
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        // an older target preempts, even if the ROB releases this cycle;
        // anything not older is already being squashed
        if (w_sel_valid && (w_sel_age < w_pend_age)) begin
          w_accept = 1'b1;
          w_next   = ISSUE;
        end else if (!rob_stall_rename) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_target    <= '0;
      r_pend_pc        <= '0;
      r_start_flush    <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_frontend_stall <= 1'b0;
      r_busy           <= 1'b0;
      r_flush_count    <= '0;
    end else begin
      if (w_accept) begin
        r_pend_target <= w_sel_target[INST_ID_BITS-1:0];
        r_pend_pc     <= w_sel_pc;
      end
      r_start_flush    <= (w_next == ISSUE);
      r_redirect_valid <= (w_next == ISSUE) || w_redir_only;
      r_frontend_stall <= (w_next != IDLE) || w_redir_only;
      r_busy           <= (w_next != IDLE);
      if ((w_next == ISSUE) && (r_flush_count != {CNT_BITS{1'b1}}))
        r_flush_count <= r_flush_count + CNT_BITS'(1);
    end
  end

  assign start_flush    = r_start_flush;
  assign start_flush_to = r_pend_target;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_pend_pc;
  assign frontend_stall = r_frontend_stall;
  assign busy           = r_busy;
  assign flush_count    = r_flush_count;

endmodule

// File: tb/tb_flush_arbiter.sv
// Self-checking bench for flush_arbiter: directed scenarios plus a randomized
// run scored against a rule-level model of the arbiter.
module tb_flush_arbiter;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           br_valid;
  logic [1:0][5:0]      br_inst_id;
  logic [1:0][63:0]     br_target_pc;
  logic [5:0]           rob_tail;
  logic [5:0]           rob_head;
  logic                 rob_stall_rename;
  logic                 start_flush;
  logic [5:0]           start_flush_to;
  logic                 redirect_valid;
  logic [63:0]          redirect_pc;
  logic                 frontend_stall;
  logic                 busy;
  logic [15:0]          flush_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  // model state: in a flush, flush issued at the last edge, target, pc, count
  bit          m_fl;
  bit          m_new;
  int          m_tgt;
  logic [63:0] m_pc;
  int          m_cnt;
  bit          e_sf, e_rv, e_fs, e_bz, e_rst;

  flush_arbiter #(.INST_ID_BITS(6), .BR_COUNT(2), .CNT_BITS(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .br_valid         (br_valid),
    .br_inst_id       (br_inst_id),
    .br_target_pc     (br_target_pc),
    .rob_tail         (rob_tail),
    .rob_head         (rob_head),
    .rob_stall_rename (rob_stall_rename),
    .start_flush      (start_flush),
    .start_flush_to   (start_flush_to),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .frontend_stall   (frontend_stall),
    .busy             (busy),
    .flush_count      (flush_count)
  );

  always #5 clk = ~clk;

  wire [19:0] ctl = {start_flush, redirect_valid, frontend_stall, busy, flush_count};

  function automatic logic [19:0] ctl_of(input logic sf, input logic rv, input logic fs,
                                         input logic bz, input int cnt);
    return {sf, rv, fs, bz, 16'(cnt)};
  endfunction

  function automatic int agef(input int t, input int tl);
    return (t - tl + 64) % 64;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; br_valid = '0; br_inst_id = '0; br_target_pc = '0;
    rob_tail = '0; rob_head = '0; rob_stall_rename = 1'b0;
    tick(); tick();
    checks++;
    if ({ctl, start_flush_to, redirect_pc} !== '0) begin
      errors++; $display("FAIL reset_state got ctl=%h to=%0d pc=%h want all 0", ctl, start_flush_to, redirect_pc);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ctl !== ctl_of(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_idle got %h want %h", ctl, ctl_of(0, 0, 0, 0, 0));
    end
    exp_cnt = 0;
  endtask

  task automatic test_single_flush();
    rob_tail = 6'd2; rob_head = 6'd10; rob_stall_rename = 1'b0;
    br_valid = 2'b01; br_inst_id[0] = 6'd5; br_target_pc[0] = 64'h400;
    tick(); br_valid = '0; exp_cnt++;
    checks++;
    if (ctl !== ctl_of(1, 1, 1, 1, exp_cnt)) begin
      errors++; $display("FAIL single_issue got %h want %h", ctl, ctl_of(1, 1, 1, 1, exp_cnt));
    end
    checks++;
    if (start_flush_to !== 6'd6 || redirect_pc !== 64'h400) begin
      errors++; $display("FAIL single_target got to=%0d pc=%h want to=6 pc=400", start_flush_to, redirect_pc);
    end
    rob_stall_rename = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ctl !== ctl_of(0, 0, 1, 1, exp_cnt)) begin
        errors++; $display("FAIL single_wait%0d got %h want %h", k, ctl, ctl_of(0, 0, 1, 1, exp_cnt));
      end
    end
    rob_stall_rename = 1'b0;
    tick();
    checks++;
    if (ctl !== ctl_of(0, 0, 0, 0, exp_cnt)) begin
      errors++; $display("FAIL single_release got %h want %h", ctl, ctl_of(0, 0, 0, 0, exp_cnt));
    end
  endtask

  task automatic test_oldest_select();
    rob_tail = 6'd60; rob_head = 6'd8; rob_stall_rename = 1'b0;
    br_valid = 2'b11;
    br_inst_id[0] = 6'd3;  br_target_pc[0] = 64'hA000;
    br_inst_id[1] = 6'd62; br_target_pc[1] = 64'hB000;
    tick(); br_valid = '0; exp_cnt++;
    checks++;
    if (ctl !== ctl_of(1, 1, 1, 1, exp_cnt)) begin
      errors++; $display("FAIL oldest_issue got %h want %h", ctl, ctl_of(1, 1, 1, 1, exp_cnt));
    end
    checks++;
    if (start_flush_to !== 6'd63 || redirect_pc !== 64'hB000) begin
      errors++; $display("FAIL oldest_pick got to=%0d pc=%h want to=63 pc=b000", start_flush_to, redirect_pc);
    end
    tick(); tick();
    checks++;
    if (ctl !== ctl_of(0, 0, 0, 0, exp_cnt)) begin
      errors++; $display("FAIL oldest_min_occupancy got %h want %h", ctl, ctl_of(0, 0, 0, 0, exp_cnt));
    end
  endtask

  task automatic test_preempt();
    rob_tail = 6'd10; rob_head = 6'd40; rob_stall_rename = 1'b0;
    br_valid = 2'b01; br_inst_id[0] = 6'd19; br_target_pc[0] = 64'h2000;
    tick(); br_valid = '0; exp_cnt++;
    checks++;
    if (ctl !== ctl_of(1, 1, 1, 1, exp_cnt) || start_flush_to !== 6'd20) begin
      errors++; $display("FAIL preempt_first got %h to=%0d want %h to=20", ctl, start_flush_to, ctl_of(1, 1, 1, 1, exp_cnt));
    end
    rob_stall_rename = 1'b1;
    tick();
    // older request arrives in the same cycle the ROB releases: preemption wins
    br_valid = 2'b10; br_inst_id[1] = 6'd15; br_target_pc[1] = 64'h1600; rob_stall_rename = 1'b0;
    tick(); br_valid = '0; exp_cnt++;
    checks++;
    if (ctl !== ctl_of(1, 1, 1, 1, exp_cnt) || start_flush_to !== 6'd16 || redirect_pc !== 64'h1600) begin
      errors++; $display("FAIL preempt_second got %h to=%0d pc=%h want %h to=16 pc=1600", ctl, start_flush_to, redirect_pc, ctl_of(1, 1, 1, 1, exp_cnt));
    end
    rob_stall_rename = 1'b1;
    tick();
    br_valid = 2'b01; br_inst_id[0] = 6'd25; br_target_pc[0] = 64'h2500;
    tick(); br_valid = '0;
    checks++;
    if (ctl !== ctl_of(0, 0, 1, 1, exp_cnt)) begin
      errors++; $display("FAIL preempt_younger_dropped got %h want %h", ctl, ctl_of(0, 0, 1, 1, exp_cnt));
    end
    br_valid = 2'b01; br_inst_id[0] = 6'd15; br_target_pc[0] = 64'h1500;
    tick(); br_valid = '0;
    checks++;
    if (ctl !== ctl_of(0, 0, 1, 1, exp_cnt)) begin
      errors++; $display("FAIL preempt_equal_dropped got %h want %h", ctl, ctl_of(0, 0, 1, 1, exp_cnt));
    end
    rob_stall_rename = 1'b0;
    tick();
    checks++;
    if (ctl !== ctl_of(0, 0, 0, 0, exp_cnt)) begin
      errors++; $display("FAIL preempt_release got %h want %h", ctl, ctl_of(0, 0, 0, 0, exp_cnt));
    end
  endtask

  task automatic test_redirect_only();
    rob_tail = 6'd4; rob_head = 6'd8; rob_stall_rename = 1'b0;
    br_valid = 2'b01; br_inst_id[0] = 6'd7; br_target_pc[0] = 64'h7777;
    tick(); br_valid = '0;
    checks++;
    if (ctl !== ctl_of(0, 1, 1, 0, exp_cnt) || redirect_pc !== 64'h7777) begin
      errors++; $display("FAIL redir_only got %h pc=%h want %h pc=7777", ctl, redirect_pc, ctl_of(0, 1, 1, 0, exp_cnt));
    end
    tick();
    checks++;
    if (ctl !== ctl_of(0, 0, 0, 0, exp_cnt)) begin
      errors++; $display("FAIL redir_only_idle got %h want %h", ctl, ctl_of(0, 0, 0, 0, exp_cnt));
    end
  endtask

  task automatic test_wrap();
    rob_tail = 6'd50; rob_head = 6'd5; rob_stall_rename = 1'b0;
    br_valid = 2'b01; br_inst_id[0] = 6'd63; br_target_pc[0] = 64'h6300;
    tick(); br_valid = '0; exp_cnt++;
    checks++;
    if (ctl !== ctl_of(1, 1, 1, 1, exp_cnt) || start_flush_to !== 6'd0) begin
      errors++; $display("FAIL wrap_target got %h to=%0d want %h to=0", ctl, start_flush_to, ctl_of(1, 1, 1, 1, exp_cnt));
    end
    tick(); tick();
    checks++;
    if (ctl !== ctl_of(0, 0, 0, 0, exp_cnt)) begin
      errors++; $display("FAIL wrap_idle got %h want %h", ctl, ctl_of(0, 0, 0, 0, exp_cnt));
    end
  endtask

  task automatic test_reset_mid_wait();
    rob_tail = 6'd0; rob_head = 6'd30; rob_stall_rename = 1'b1;
    br_valid = 2'b01; br_inst_id[0] = 6'd9; br_target_pc[0] = 64'h900;
    tick(); br_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({ctl, start_flush_to, redirect_pc} !== '0) begin
      errors++; $display("FAIL reset_mid_wait got ctl=%h to=%0d pc=%h want all 0", ctl, start_flush_to, redirect_pc);
    end
    rst = 1'b0; rob_stall_rename = 1'b0; exp_cnt = 1;
    br_valid = 2'b01; br_inst_id[0] = 6'd3; br_target_pc[0] = 64'h3300;
    tick(); br_valid = '0;
    checks++;
    if (ctl !== ctl_of(1, 1, 1, 1, exp_cnt) || start_flush_to !== 6'd4 || redirect_pc !== 64'h3300) begin
      errors++; $display("FAIL post_reset_flush got %h to=%0d pc=%h want %h to=4 pc=3300", ctl, start_flush_to, redirect_pc, ctl_of(1, 1, 1, 1, exp_cnt));
    end
    tick(); tick();
  endtask

  // Reference model: applies the arbitration rules to the inputs present at
  // the coming edge and produces the outputs expected just after it.
  task automatic model_step();
    int  best = -1;
    int  bt   = 0;
    int  ba   = 0;
    bit  take = 1'b0;
    e_sf = 1'b0; e_rv = 1'b0; e_rst = rst;
    for (int i = 0; i < 2; i++) begin
      if (br_valid[i]) begin
        int t = (int'(br_inst_id[i]) + 1) % 64;
        int a = agef(t, int'(rob_tail));
        if (best < 0 || a < ba) begin best = i; bt = t; ba = a; end
      end
    end
    if (rst) begin
      m_fl = 1'b0; m_new = 1'b0; m_cnt = 0; e_fs = 1'b0;
    end else if (!m_fl) begin
      e_fs = 1'b0;
      if (best >= 0) begin
        m_tgt = bt; m_pc = br_target_pc[best]; e_rv = 1'b1;
        if (bt == int'(rob_head)) e_fs = 1'b1;
        else                      take = 1'b1;
      end
    end else if (m_new) begin
      m_new = 1'b0; e_fs = 1'b1;
    end else if (best >= 0 && ba < agef(m_tgt, int'(rob_tail))) begin
      m_tgt = bt; m_pc = br_target_pc[best]; e_rv = 1'b1; take = 1'b1;
    end else if (!rob_stall_rename) begin
      m_fl = 1'b0; e_fs = 1'b0;
    end else begin
      e_fs = 1'b1;
    end
    if (take) begin
      m_fl = 1'b1; m_new = 1'b1; e_sf = 1'b1; e_fs = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    e_bz = m_fl;
  endtask

  task automatic test_random();
    rst = 1'b1; br_valid = '0; model_step();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(399) == 0);
      if ($urandom_range(2) == 0) rob_tail = rob_tail + 6'($urandom_range(0, 3));
      if ($urandom_range(3) == 0) rob_head = rob_tail + 6'($urandom_range(1, 50));
      rob_stall_rename = ($urandom_range(3) != 0);
      for (int i = 0; i < 2; i++) begin
        br_valid[i] = ($urandom_range(3) == 0);
        case ($urandom_range(5))
          0:       br_inst_id[i] = rob_head - 6'd1;
          1:       br_inst_id[i] = br_inst_id[0];
          default: br_inst_id[i] = rob_tail + 6'($urandom_range(0, 45));
        endcase
        br_target_pc[i] = {$urandom, $urandom};
      end
      model_step();
      tick();
      checks++;
      if (ctl !== ctl_of(e_sf, e_rv, e_fs, e_bz, m_cnt)) begin
        errors++; $display("FAIL rand_ctl n=%0d got %h want %h", n, ctl, ctl_of(e_sf, e_rv, e_fs, e_bz, m_cnt));
      end
      if (e_sf) begin
        checks++;
        if (start_flush_to !== 6'(m_tgt)) begin
          errors++; $display("FAIL rand_to n=%0d got %0d want %0d", n, start_flush_to, m_tgt);
        end
      end
      if (e_rv) begin
        checks++;
        if (redirect_pc !== m_pc) begin
          errors++; $display("FAIL rand_pc n=%0d got %h want %h", n, redirect_pc, m_pc);
        end
      end
      if (e_rst) begin
        checks++;
        if ({start_flush_to, redirect_pc} !== '0) begin
          errors++; $display("FAIL rand_reset n=%0d got to=%0d pc=%h want 0", n, start_flush_to, redirect_pc);
        end
      end
    end
    rst = 1'b0; br_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_flush();
    test_oldest_select();
    test_preempt();
    test_redirect_only();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
